clip_record_play_ctrl: RTL and testbench

Parametrised record/playback controller for the voice-clip recorder. It supports NUM_CLIPS independent clips in one shared single-port BRAM, addressed as {clip, offset}. It tracks the recorded length of each clip, so playback stops at the recorded length, not at the full region. It sits between the button synchronizers, the deserializer (sample source), the BRAM and the serializer (sample sink). It replaces the per-memory address counters and the fixed two-clip controller.

---
 rtl/clip_record_play_ctrl_if.sv | 45 ++++
 rtl/clip_record_play_ctrl.sv | 152 +++++++++++++++
 tb/tb_clip_record_play_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clip_record_play_ctrl_if.sv
// Bus bundle for the clip record/playback controller: request pulses, sample
// source/sink handshakes, shared BRAM port and status.
interface clip_record_play_ctrl_if #(
    parameter int NUM_CLIPS  = 4,
    parameter int DATA_W     = 8,
    parameter int CLIP_DEPTH = 32768
);
    localparam int CLIP_W  = $clog2(NUM_CLIPS);
    localparam int DEPTH_W = $clog2(CLIP_DEPTH);
    localparam int ADDR_W  = CLIP_W + DEPTH_W;

    logic                 record_req;
    logic                 play_req;
    logic                 stop_req;
    logic [CLIP_W-1:0]    clip_sel;
    logic                 sample_in_valid;
    logic [DATA_W-1:0]    sample_in;
    logic                 mem_en;
    logic                 mem_wen;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    logic [DATA_W-1:0]    sample_out;
    logic                 sample_out_valid;
    logic                 sample_out_ready;
    logic                 des_enable;
    logic                 ser_enable;
    logic [CLIP_W-1:0]    active_clip;
    logic [NUM_CLIPS-1:0] clip_valid;
    logic                 busy;

    modport master (
        input  record_req, play_req, stop_req, clip_sel, sample_in_valid, sample_in,
               mem_rdata, sample_out_ready,
        output mem_en, mem_wen, mem_addr, mem_wdata, sample_out, sample_out_valid,
               des_enable, ser_enable, active_clip, clip_valid, busy
    );

    modport slave (
        output record_req, play_req, stop_req, clip_sel, sample_in_valid, sample_in,
               mem_rdata, sample_out_ready,
        input  mem_en, mem_wen, mem_addr, mem_wdata, sample_out, sample_out_valid,
               des_enable, ser_enable, active_clip, clip_valid, busy
    );
endinterface

// File: rtl/clip_record_play_ctrl.sv
// Record/playback controller for NUM_CLIPS clips sharing one single-port BRAM
// addressed as {clip, offset}; tracks each clip's recorded length.
module clip_record_play_ctrl #(
    parameter int NUM_CLIPS  = 4,
    parameter int DATA_W     = 8,
    parameter int CLIP_DEPTH = 32768,
    parameter int LOOP_PLAY  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    clip_record_play_ctrl_if.master bus
);
    localparam int CLIP_W  = $clog2(NUM_CLIPS);
    localparam int DEPTH_W = $clog2(CLIP_DEPTH);
    localparam int LEN_W   = DEPTH_W + 1;
    localparam logic [LEN_W-1:0] LAST_OFF = LEN_W'(CLIP_DEPTH - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(CLIP_DEPTH);

    typedef enum logic [2:0] {IDLE, REC, P_RD, P_WAIT, P_OUT} state_t;

    state_t               state, state_nxt;
    logic [LEN_W-1:0]     offset, offset_nxt, off_inc;
    logic [CLIP_W-1:0]    clip_r, clip_nxt;
    logic [LEN_W-1:0]     clip_len [NUM_CLIPS];
    logic [NUM_CLIPS-1:0] valid_r;
    logic                 wr_issue, rd_issue, len_upd, capture, out_clr;
    logic [LEN_W-1:0]     len_new;
    logic [DEPTH_W-1:0]   mem_off;

    assign off_inc = offset + LEN_W'(1);
    assign mem_off = wr_issue ? offset[DEPTH_W-1:0] : offset_nxt[DEPTH_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        clip_nxt   = clip_r;
        wr_issue   = 1'b0;
        rd_issue   = 1'b0;
        len_upd    = 1'b0;
        len_new    = '0;
        capture    = 1'b0;
        out_clr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.record_req) begin
                    state_nxt  = REC;
                    clip_nxt   = bus.clip_sel;
                    offset_nxt = '0;
                end else if (bus.play_req && valid_r[bus.clip_sel]) begin
                    state_nxt  = P_RD;
                    clip_nxt   = bus.clip_sel;
                    offset_nxt = '0;
                    rd_issue   = 1'b1;
                end
            end
            REC: begin
                if (bus.sample_in_valid) begin
                    wr_issue   = 1'b1;
                    offset_nxt = off_inc;
                end
                // The last slot of the region closes the take even without stop.
                if (bus.sample_in_valid && offset == LAST_OFF) begin
                    len_upd   = 1'b1;
                    len_new   = FULL_LEN;
                    state_nxt = IDLE;
                end else if (bus.stop_req) begin
                    len_upd   = 1'b1;
                    len_new   = offset + LEN_W'(bus.sample_in_valid);
                    state_nxt = IDLE;
                end
            end
            P_RD: begin
                state_nxt = bus.stop_req ? IDLE : P_WAIT;
            end
            P_WAIT: begin
                if (bus.stop_req) begin
                    state_nxt = IDLE;
                end else begin
                    capture   = 1'b1;
                    state_nxt = P_OUT;
                end
            end
            P_OUT: begin
                if (bus.stop_req) begin
                    out_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.sample_out_ready) begin
                    out_clr = 1'b1;
                    if (off_inc == clip_len[clip_r]) begin
                        if (LOOP_PLAY != 0) begin
                            offset_nxt = '0;
                            rd_issue   = 1'b1;
                            state_nxt  = P_RD;
                        end else begin
                            offset_nxt = off_inc;
                            state_nxt  = IDLE;
                        end
                    end else begin
                        offset_nxt = off_inc;
                        rd_issue   = 1'b1;
                        state_nxt  = P_RD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered BRAM port, output stage and per-clip length table.
    always_ff @(posedge clock) begin
        if (!reset) begin
            offset               <= '0;
            clip_r               <= '0;
            valid_r              <= '0;
            for (int i = 0; i < NUM_CLIPS; i++) clip_len[i] <= '0;
            bus.mem_en           <= 1'b0;
            bus.mem_wen          <= 1'b0;
            bus.mem_addr         <= '0;
            bus.mem_wdata        <= '0;
            bus.sample_out       <= '0;
            bus.sample_out_valid <= 1'b0;
        end else begin
            offset      <= offset_nxt;
            clip_r      <= clip_nxt;
            bus.mem_en  <= wr_issue || rd_issue;
            bus.mem_wen <= wr_issue;
            if (wr_issue || rd_issue) bus.mem_addr <= {clip_nxt, mem_off};
            if (wr_issue) bus.mem_wdata <= bus.sample_in;
            if (len_upd) begin
                clip_len[clip_r] <= len_new;
                valid_r[clip_r]  <= (len_new != '0);
            end
            if (capture) begin
                bus.sample_out       <= bus.mem_rdata;
                bus.sample_out_valid <= 1'b1;
            end else if (out_clr) begin
                bus.sample_out_valid <= 1'b0;
            end
        end
    end

    assign bus.des_enable  = (state == REC);
    assign bus.ser_enable  = (state == P_RD) || (state == P_WAIT) || (state == P_OUT);
    assign bus.busy        = (state != IDLE);
    assign bus.active_clip = clip_r;
    assign bus.clip_valid  = valid_r;
endmodule

// File: tb/tb_clip_record_play_ctrl.sv
// Randomized bench: one-shot and looping controllers share stimulus and are
// checked against a clip-content/length model and a BRAM model.
module tb_clip_record_play_ctrl;
    localparam int NC    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(NC);
    localparam int DPW   = $clog2(DEPTH);
    localparam int AW    = CW + DPW;
    localparam int OW    = 2 * DW + AW + CW + NC + 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          record_req = 1'b0, play_req = 1'b0, stop_req = 1'b0;
    logic          sample_in_valid = 1'b0, sample_out_ready = 1'b0;
    logic [CW-1:0] clip_sel = '0;
    logic [DW-1:0] sample_in = '0;

    int n_checks = 0;
    int n_errors = 0;
    int ref_len  [NC];
    int ref_data [NC][DEPTH];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        clip_record_play_ctrl_if #(.NUM_CLIPS(NC), .DATA_W(DW), .CLIP_DEPTH(DEPTH)) bus ();
        clip_record_play_ctrl #(.NUM_CLIPS(NC), .DATA_W(DW), .CLIP_DEPTH(DEPTH), .LOOP_PLAY(g)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        logic [DW-1:0] mem [NC*DEPTH];
        logic [DW-1:0] rdata = '0;
        logic [OW-1:0] outs;
        logic          busy_o, valid_o, ser_o, des_o;
        logic [CW-1:0] clip_o;
        logic [NC-1:0] cv_o;
        logic [DW-1:0] sout_o;
        int            wr_addr_q[$], wr_data_q[$], rd_addr_q[$], xfer_q[$];
        int            busy_cycles = 0;
        int            hold_err = 0;
        logic          hold_pend = 1'b0;
        logic [DW-1:0] hold_val = '0;

        assign bus.record_req       = record_req;
        assign bus.play_req         = play_req;
        assign bus.stop_req         = stop_req;
        assign bus.clip_sel         = clip_sel;
        assign bus.sample_in_valid  = sample_in_valid;
        assign bus.sample_in        = sample_in;
        assign bus.sample_out_ready = sample_out_ready;
        assign bus.mem_rdata        = rdata;
        assign outs   = {bus.mem_en, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.sample_out,
                         bus.sample_out_valid, bus.des_enable, bus.ser_enable, bus.active_clip,
                         bus.clip_valid, bus.busy};
        assign busy_o  = bus.busy;
        assign valid_o = bus.sample_out_valid;
        assign ser_o   = bus.ser_enable;
        assign des_o   = bus.des_enable;
        assign clip_o  = bus.active_clip;
        assign cv_o    = bus.clip_valid;
        assign sout_o  = bus.sample_out;

        always @(posedge clock) begin
            if (bus.mem_en) begin
                if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
                else             rdata <= mem[bus.mem_addr];
            end
        end

        always @(negedge clock) begin
            if (bus.mem_en && bus.mem_wen) begin
                wr_addr_q.push_back(int'(bus.mem_addr));
                wr_data_q.push_back(int'(bus.mem_wdata));
            end
            if (bus.mem_en && !bus.mem_wen) rd_addr_q.push_back(int'(bus.mem_addr));
            if (bus.sample_out_valid && bus.sample_out_ready) xfer_q.push_back(int'(bus.sample_out));
            if (bus.busy) busy_cycles++;
            if (hold_pend && bus.sample_out_valid && bus.sample_out != hold_val) hold_err++;
            hold_pend = bus.sample_out_valid && !bus.sample_out_ready && reset;
            hold_val  = bus.sample_out;
        end
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NC-1:0] exp_cv();
        logic [NC-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) v[c] = (ref_len[c] != 0);
        return v;
    endfunction

    task automatic apply_reset(input string tag);
        record_req = 0; play_req = 0; stop_req = 0; sample_in_valid = 0;
        reset = 1'b0;
        tick();
        check_val({tag, "_oneshot"}, longint'(g_dut[0].outs), 0);
        check_val({tag, "_loop"},    longint'(g_dut[1].outs), 0);
        reset = 1'b1;
        for (int c = 0; c < NC; c++) ref_len[c] = 0;
    endtask

    task automatic do_record(input int clip, input int n, input bit stop_last, input int base,
                             input bit with_play);
        int exp_n, s0, s1, gap, data;
        exp_n = (n > DEPTH) ? DEPTH : n;
        s0 = g_dut[0].wr_addr_q.size();
        s1 = g_dut[1].wr_addr_q.size();
        clip_sel = CW'(clip); record_req = 1; play_req = with_play;
        tick();
        record_req = 0; play_req = 0;
        check_val("rec_enter", {g_dut[0].des_o, g_dut[0].clip_o, g_dut[1].des_o, g_dut[1].clip_o},
                  {1'b1, CW'(clip), 1'b1, CW'(clip)});
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                clip_sel = CW'($urandom);
                if (i < DEPTH) begin
                    record_req = ($urandom_range(0, 3) == 0);
                    play_req   = ($urandom_range(0, 3) == 0);
                end
                tick();
                record_req = 0; play_req = 0;
            end
            data = (base < 0) ? int'($urandom_range(0, 255)) : base + i;
            if (i < DEPTH) ref_data[clip][i] = data;
            sample_in_valid = 1; sample_in = DW'(data);
            stop_req = stop_last && (i == n - 1);
            tick();
            sample_in_valid = 0; stop_req = 0;
        end
        if (!stop_last || n == 0) begin
            stop_req = 1;
            tick();
            stop_req = 0;
        end
        tick();
        ref_len[clip] = exp_n;
        check_val("rec_wr_cnt0", g_dut[0].wr_addr_q.size() - s0, exp_n);
        check_val("rec_wr_cnt1", g_dut[1].wr_addr_q.size() - s1, exp_n);
        for (int i = 0; i < exp_n && s0 + i < g_dut[0].wr_addr_q.size(); i++) begin
            check_val("rec_wr_addr", g_dut[0].wr_addr_q[s0 + i], clip * DEPTH + i);
            check_val("rec_wr_data", g_dut[0].wr_data_q[s0 + i], ref_data[clip][i]);
        end
        check_val("rec_idle", {g_dut[0].busy_o, g_dut[0].des_o, g_dut[1].busy_o, g_dut[1].des_o}, 0);
        check_val("rec_cv0", g_dut[0].cv_o, exp_cv());
        check_val("rec_cv1", g_dut[1].cv_o, exp_cv());
    endtask

    function automatic logic next_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return (cyc % 2) == 0;
    endfunction

    task automatic do_play(input int clip, input int rmode, input int stop_at);
        int L, x0, x1, r0, r1, b0, cyc, n0, n1, idx;
        L  = ref_len[clip];
        x0 = g_dut[0].xfer_q.size();    x1 = g_dut[1].xfer_q.size();
        r0 = g_dut[0].rd_addr_q.size(); r1 = g_dut[1].rd_addr_q.size();
        b0 = g_dut[0].busy_cycles;
        clip_sel = CW'(clip); play_req = 1; sample_out_ready = next_ready(rmode, 0);
        tick();
        play_req = 0;
        if (L == 0) begin
            check_val("play_empty", {g_dut[0].busy_o, g_dut[1].busy_o}, 0);
            tick();
            return;
        end
        check_val("play_enter", {g_dut[0].ser_o, g_dut[0].des_o, g_dut[0].clip_o,
                                 g_dut[1].ser_o, g_dut[1].des_o, g_dut[1].clip_o},
                  {1'b1, 1'b0, CW'(clip), 1'b1, 1'b0, CW'(clip)});
        cyc = 0;
        while (cyc < 2000) begin
            n0 = g_dut[0].xfer_q.size() - x0;
            n1 = g_dut[1].xfer_q.size() - x1;
            if (stop_at > 0 && n0 >= stop_at) break;
            if (stop_at == 0 && !g_dut[0].busy_o && n1 >= L + 2) break;
            sample_out_ready = next_ready(rmode, cyc + 1);
            if (g_dut[0].busy_o && g_dut[1].busy_o && $urandom_range(0, 4) == 0) begin
                record_req = 1; play_req = 1; clip_sel = CW'($urandom);
            end
            tick();
            record_req = 0; play_req = 0;
            cyc++;
        end
        check_val("play_timeout", cyc < 2000, 1);
        stop_req = 1;
        tick();
        stop_req = 0;
        check_val("play_stop", {g_dut[0].busy_o, g_dut[0].valid_o, g_dut[0].ser_o,
                                g_dut[1].busy_o, g_dut[1].valid_o, g_dut[1].ser_o}, 0);
        n0 = g_dut[0].xfer_q.size() - x0;
        n1 = g_dut[1].xfer_q.size() - x1;
        if (stop_at == 0) begin
            check_val("play_cnt", n0, L);
            check_val("play_rd_cnt", g_dut[0].rd_addr_q.size() - r0, L);
            check_val("play_loop_cnt", n1 >= L + 2, 1);
            if (rmode == 0) check_val("play_rate", g_dut[0].busy_cycles - b0, 3 * L);
        end else begin
            check_val("play_early_cnt", (n0 >= stop_at) && (n0 <= L), 1);
        end
        for (int k = 0; k < n0 && k < L; k++)
            check_val("play_data", g_dut[0].xfer_q[x0 + k], ref_data[clip][k]);
        for (int k = 0; k < n1; k++)
            check_val("loop_data", g_dut[1].xfer_q[x1 + k], ref_data[clip][k % L]);
        for (int k = 0; r0 + k < g_dut[0].rd_addr_q.size(); k++)
            check_val("play_rd_addr", g_dut[0].rd_addr_q[r0 + k], clip * DEPTH + (k % L));
        for (int k = 0; r1 + k < g_dut[1].rd_addr_q.size(); k++)
            check_val("loop_rd_addr", g_dut[1].rd_addr_q[r1 + k], clip * DEPTH + (k % L));
        tick();
    endtask

    initial begin
        int c, L, sa, w;
        for (int i = 0; i < NC; i++) ref_len[i] = 0;
        tick(); tick();
        apply_reset("reset_state");
        tick();

        do_record(2, 5, 1'b0, 'h10, 1'b0);
        check_val("cv_clip2", g_dut[0].cv_o, 4'b0100);
        do_play(2, 0, 0);
        do_play(0, 1, 0);
        do_record(2, 3, 1'b0, 'h20, 1'b1);
        do_record(1, 10, 1'b0, 'h40, 1'b0);
        do_play(1, 2, 0);
        do_record(0, 3, 1'b1, -1, 1'b0);
        do_play(0, 2, 0);
        do_play(1, 0, 3);

        for (int it = 0; it < 40; it++) begin
            c = $urandom_range(0, NC - 1);
            if ($urandom_range(0, 1) == 1) begin
                do_record(c, $urandom_range(0, 11), 1'($urandom_range(0, 1)), -1,
                          1'($urandom_range(0, 3) == 0));
            end else begin
                L  = ref_len[c];
                sa = 0;
                if (L >= 2 && $urandom_range(0, 3) == 0) sa = $urandom_range(1, L - 1);
                do_play(c, $urandom_range(0, 2), sa);
            end
        end

        clip_sel = 2'd3; record_req = 1;
        tick();
        record_req = 0;
        for (int i = 0; i < 3; i++) begin
            sample_in_valid = 1; sample_in = DW'(i + 1);
            tick();
        end
        apply_reset("reset_mid_rec");
        tick();

        do_record(1, 4, 1'b0, 'h60, 1'b0);
        clip_sel = 2'd1; play_req = 1; sample_out_ready = 0;
        tick();
        play_req = 0;
        w = 0;
        while (!(g_dut[0].valid_o && g_dut[1].valid_o) && w < 10) begin
            tick();
            w++;
        end
        check_val("pout_valid", {g_dut[0].valid_o, g_dut[1].valid_o}, 2'b11);
        tick(); tick();
        check_val("pout_hold0", g_dut[0].sout_o, 'h60);
        check_val("pout_hold1", g_dut[1].sout_o, 'h60);
        apply_reset("reset_mid_pout");
        clip_sel = 2'd1; play_req = 1;
        tick();
        play_req = 0;
        check_val("play_after_reset", {g_dut[0].busy_o, g_dut[1].busy_o}, 0);
        tick();

        check_val("hold_oneshot", g_dut[0].hold_err, 0);
        check_val("hold_loop",    g_dut[1].hold_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
